// File: rtl/conv_line_buffer.sv
// K-row line buffer: stores the previous K-1 image rows in circular row memories and
// emits one K-tall vertical window column per accepted raster-order pixel.
module conv_line_buffer #(
  parameter int WORDWIDTH  = 32,
  parameter int K          = 3,
  parameter int MAX_WIDTH  = 28,
  parameter int ADDRLEN    = 5,
  parameter int MAX_HEIGHT = 28,
  parameter int ROWLEN     = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic [ADDRLEN:0]       cfg_width,
  input  logic [ROWLEN:0]        cfg_height,
  input  logic [WORDWIDTH-1:0]   din,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [K*WORDWIDTH-1:0] dout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDRLEN-1:0]     out_col,
  output logic [ROWLEN-1:0]      out_row,
  output logic                   frame_done
);

  typedef enum logic {PRIME, STREAM} state_t;

  localparam logic [ADDRLEN:0]   MAX_W      = (ADDRLEN+1)'(MAX_WIDTH);
  localparam logic [ROWLEN:0]    MAX_H      = (ROWLEN+1)'(MAX_HEIGHT);
  localparam logic [ADDRLEN:0]   W_ONE      = (ADDRLEN+1)'(1);
  localparam logic [ROWLEN:0]    H_ONE      = (ROWLEN+1)'(1);
  localparam logic [ADDRLEN-1:0] COL_ONE    = ADDRLEN'(1);
  localparam logic [ROWLEN-1:0]  ROW_ONE    = ROWLEN'(1);
  localparam logic [ROWLEN-1:0]  PRIME_ROWS = ROWLEN'(K-1);

  state_t                 state;
  logic [ADDRLEN-1:0]     col;
  logic [ROWLEN-1:0]      row;
  logic [ADDRLEN:0]       width_q;
  logic [ROWLEN:0]        height_q;
  logic [ADDRLEN:0]       width_clamped;
  logic [ROWLEN:0]        height_clamped;
  logic                   accept;
  logic                   last_col;
  logic                   last_row;
  logic [K*WORDWIDTH-1:0] cand;
  logic [WORDWIDTH-1:0]   mem [K-1][MAX_WIDTH];

  assign in_ready = (~out_valid | out_ready) & ~frame_start;
  assign accept   = in_valid & in_ready;
  assign last_col = ({1'b0, col} == width_q - W_ONE);
  assign last_row = ({1'b0, row} == height_q - H_ONE);

  always_comb begin
    width_clamped  = cfg_width;
    height_clamped = cfg_height;
    if (cfg_width == '0 || cfg_width > MAX_W) width_clamped = MAX_W;
    if (cfg_height == '0 || cfg_height > MAX_H) height_clamped = MAX_H;
  end

  // Oldest stored row lands in the top slice, the live pixel in the bottom slice.
  always_comb begin
    cand = '0;
    cand[WORDWIDTH-1:0] = din;
    for (int i = 0; i < K-1; i++) begin
      cand[(i+2)*WORDWIDTH-1 -: WORDWIDTH] = mem[i][col];
    end
  end

  // Row memories are never reset; PRIME overwrites whatever a previous frame left behind.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[0][col] <= din;
      for (int i = 1; i < K-1; i++) begin
        mem[i][col] <= mem[i-1][col];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PRIME;
      col        <= '0;
      row        <= '0;
      width_q    <= MAX_W;
      height_q   <= MAX_H;
      out_valid  <= 1'b0;
      dout       <= '0;
      out_col    <= '0;
      out_row    <= '0;
      frame_done <= 1'b0;
    end else if (frame_start) begin
      width_q    <= width_clamped;
      height_q   <= height_clamped;
      col        <= '0;
      row        <= '0;
      state      <= PRIME;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (state == STREAM) begin
          out_valid <= 1'b1;
          dout      <= cand;
          out_col   <= col;
          out_row   <= row - PRIME_ROWS;
        end
        if (last_col) begin
          col <= '0;
          if (last_row) begin
            row        <= '0;
            state      <= PRIME;
            frame_done <= 1'b1;
          end else begin
            row <= row + ROW_ONE;
            if (row + ROW_ONE == PRIME_ROWS) state <= STREAM;
          end
        end else begin
          col <= col + COL_ONE;
        end
      end
    end
  end

endmodule
